// File: rtl/cp0_regfile_v2.sv
// cp0_regfile_v2: MIPS CP0 register file (BadVAddr, Count, Compare, Status,
// Cause, EPC, PRId, Config) with Count prescaler and registered int request.
// Ports: clk, rst (async active-low), int_i, MTC0 we_i/waddr_i/wdata_i,
// MFC0 raddr_i/rdata_o, exception exc_*_i, eret_i, status_o/cause_o/epc_o,
// int_req_o. Optional timer (Count/Compare/TI) built when CP0_TIMER_EN is set.
module cp0_regfile_v2 #(
  parameter int          NUM_HW_INT   = 6,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VALUE = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_req_o
);

  localparam logic [4:0] A_BADV = 5'd8;
  localparam logic [4:0] A_CNT  = 5'd9;
  localparam logic [4:0] A_CMP  = 5'd11;
  localparam logic [4:0] A_STAT = 5'd12;
  localparam logic [4:0] A_CAUS = 5'd13;
  localparam logic [4:0] A_EPC  = 5'd14;
  localparam logic [4:0] A_PRID = 5'd15;
  localparam logic [4:0] A_CFG  = 5'd16;

  logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;

  assign wr_status  = we_i && (waddr_i == A_STAT);
  assign wr_cause   = we_i && (waddr_i == A_CAUS);
  assign wr_epc     = we_i && (waddr_i == A_EPC);
  assign wr_count   = we_i && (waddr_i == A_CNT);
  assign wr_compare = we_i && (waddr_i == A_CMP);

  // Hardware lines padded to the full six IP slots; unused slots stay 0.
  logic [5:0] hw_pad;
  always_comb begin
    hw_pad = '0;
    hw_pad[NUM_HW_INT-1:0] = int_i;
  end

  logic [31:0] count_q, compare_q;
  logic        ti_q;

`ifdef CP0_TIMER_EN
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_d, compare_d;
  logic          ti_d;

  always_comb begin
    presc_d   = presc_q + 1'b1;
    count_d   = count_q;
    compare_d = compare_q;
    if (presc_q == PMAX) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
    end
    if (wr_count) begin
      count_d = wdata_i;
      presc_d = '0;
    end
    if (wr_compare) compare_d = wdata_i;
    ti_d = ti_q | ((count_q == compare_q) && (compare_q != '0));
    // Compare write acknowledges the timer; it wins over a new match.
    if (wr_compare) ti_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
`else
  assign count_q   = '0;
  assign compare_q = '0;
  assign ti_q      = 1'b0;
`endif

  logic [31:0] badv_q, badv_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [1:0]  ipsw_q, ipsw_d;
  logic [5:0]  iphw_q;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic        ireq_q, ireq_d;
  logic [7:0]  ip;

  assign ip = {iphw_q[5] | ti_q, iphw_q[4:0], ipsw_q};

  always_comb begin
    badv_d = badv_q;
    epc_d  = epc_q;
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    ipsw_d = ipsw_q;
    bd_d   = bd_q;
    code_d = code_q;
    if (wr_status) begin
      im_d  = wdata_i[15:8];
      exl_d = wdata_i[1];
      ie_d  = wdata_i[0];
    end
    if (wr_cause) ipsw_d = wdata_i[9:8];
    if (wr_epc)   epc_d  = wdata_i;
    if (eret_i)   exl_d  = 1'b0;
    if (exc_valid_i) begin
      // Nested exceptions keep the original return point.
      epc_d  = epc_q;
      ipsw_d = ipsw_q;
      if (!exl_q) begin
        epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      exl_d  = 1'b1;
      code_d = exc_code_i;
      if (exc_code_i == 5'd4 || exc_code_i == 5'd5)
        badv_d = exc_badvaddr_i;
    end
    ireq_d = ie_q & ~exl_q & |(im_q & ip);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badv_q <= '0;
      epc_q  <= '0;
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      ipsw_q <= '0;
      iphw_q <= '0;
      bd_q   <= 1'b0;
      code_q <= '0;
      ireq_q <= 1'b0;
    end else begin
      badv_q <= badv_d;
      epc_q  <= epc_d;
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      ipsw_q <= ipsw_d;
      iphw_q <= hw_pad;
      bd_q   <= bd_d;
      code_q <= code_d;
      ireq_q <= ireq_d;
    end
  end

  assign status_o = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_o  = {bd_q, ti_q, 14'd0, ip, 1'b0, code_q, 2'b00};
  assign epc_o    = epc_q;
  assign int_req_o = ireq_q;

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      A_BADV:  rdata_o = badv_q;
      A_CNT:   rdata_o = count_q;
      A_CMP:   rdata_o = compare_q;
      A_STAT:  rdata_o = status_o;
      A_CAUS:  rdata_o = cause_o;
      A_EPC:   rdata_o = epc_q;
      A_PRID:  rdata_o = PRID_VALUE;
      A_CFG:   rdata_o = CONFIG_VALUE;
      default: rdata_o = '0;
    endcase
  end

endmodule
